// File: rtl/branch_resolve_unit_pkg.sv
// Shared MIPS decode constants and the 2-bit saturating predictor helper used
// by the branch resolution stage and its history table.
package branch_resolve_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FUNC_JR    = 6'h08;
    localparam logic [5:0] FUNC_JALR  = 6'h09;
    localparam logic [5:0] FUNC_TEQ   = 6'h34;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    // Weakly not-taken: first taken outcome flips the prediction.
    localparam logic [1:0] CTR_RESET  = 2'b01;

    typedef struct packed {
        logic taken;
        logic trap;
        logic cond;
    } decode_t;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] result;
        result = ctr;
        if (taken) begin
            if (ctr != 2'b11) result = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) result = ctr - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_branch_history_table.sv
// Table of 2-bit saturating branch predictors: combinational read port for
// fetch, one saturating-update write port from ID.
module branch_history_table
    import branch_resolve_unit_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_reg  [DEPTH];
    logic [1:0] ctr_next [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign ctr_next[gi] = (wr_en && wr_idx == IDX_W'(gi))
                                  ? ctr_update(ctr_reg[gi], wr_taken)
                                  : ctr_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= CTR_RESET;
        end else begin
            for (int i = 0; i < DEPTH; i++) ctr_reg[i] <= ctr_next[i];
        end
    end

    // Read sees the pre-edge value when the same entry is written this cycle.
    assign rd_pred = ctr_reg[rd_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch/jump/trap resolution with one-cycle registered decision,
// a 2-bit predictor table for IF and a saturating mispredict counter.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 16,
    parameter bit PRED_EN   = 1'b1
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_stall,
    input  logic              in_valid,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [5:0]        in_op,
    input  logic [5:0]        in_func,
    input  logic [4:0]        in_rt,
    input  logic              in_exception,
    input  logic              in_pred_taken,
    input  logic [31:0]       in_fetch_pc,
    output logic              out_pred_taken,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_mispredict,
    output logic              out_trap,
    output logic              out_exception,
    output logic [CNT_W-1:0]  out_mispred_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    decode_t    dec;
    logic       a_neg;
    logic       a_zero;
    logic       a_eq_b;
    logic       mispred_next;
    logic       accept;
    logic       bht_pred;
    logic       unused_pc_bits;

    logic       valid_reg, taken_reg, mispredict_reg, trap_reg, exception_reg;
    logic [CNT_W-1:0] count_reg;

    assign a_neg  = in_a[DATA_W-1];
    assign a_zero = (in_a == '0);
    assign a_eq_b = (in_a == in_b);
    assign accept = in_valid && !in_stall;

    always_comb begin
        dec = '0;
        if (in_exception) begin
            dec.taken = 1'b1;
        end else begin
            case (in_op)
                OP_BEQ:  begin dec.cond = 1'b1; dec.taken = a_eq_b;             end
                OP_BNE:  begin dec.cond = 1'b1; dec.taken = !a_eq_b;            end
                OP_BLEZ: begin dec.cond = 1'b1; dec.taken = a_neg || a_zero;    end
                OP_BGTZ: begin dec.cond = 1'b1; dec.taken = !a_neg && !a_zero;  end
                OP_REGIMM: begin
                    if (in_rt == RT_BGEZ) begin
                        dec.cond  = 1'b1;
                        dec.taken = !a_neg;
                    end else if (in_rt == RT_BLTZ) begin
                        dec.cond  = 1'b1;
                        dec.taken = a_neg;
                    end
                end
                OP_J, OP_JAL: dec.taken = 1'b1;
                OP_SPECIAL: begin
                    if (in_func == FUNC_JR || in_func == FUNC_JALR) dec.taken = 1'b1;
                    else if (in_func == FUNC_TEQ)                   dec.trap  = a_eq_b;
                end
                default: dec = '0;
            endcase
        end
    end

    assign mispred_next = in_exception || (dec.taken != in_pred_taken);

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            valid_reg      <= 1'b0;
            taken_reg      <= 1'b0;
            mispredict_reg <= 1'b0;
            trap_reg       <= 1'b0;
            exception_reg  <= 1'b0;
            count_reg      <= '0;
        end else if (!in_stall) begin
            valid_reg      <= in_valid;
            taken_reg      <= in_valid && dec.taken;
            mispredict_reg <= in_valid && mispred_next;
            trap_reg       <= in_valid && dec.trap;
            exception_reg  <= in_valid && in_exception;
            if (in_valid && mispred_next && count_reg != '1)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    branch_history_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk      (in_clk),
        .rst_n    (in_rst_n),
        .rd_idx   (in_fetch_pc[IDX_W+1:2]),
        .rd_pred  (bht_pred),
        .wr_en    (PRED_EN && accept && dec.cond),
        .wr_idx   (in_pc[IDX_W+1:2]),
        .wr_taken (dec.taken)
    );

    assign unused_pc_bits = ^{in_pc[31:IDX_W+2], in_pc[1:0],
                              in_fetch_pc[31:IDX_W+2], in_fetch_pc[1:0]};

    assign out_pred_taken    = PRED_EN ? bht_pred : 1'b0;
    assign out_valid         = valid_reg;
    assign out_taken         = taken_reg;
    assign out_mispredict    = mispredict_reg;
    assign out_trap          = trap_reg;
    assign out_exception     = exception_reg;
    assign out_mispred_count = count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomised scoreboard bench for branch_resolve_unit: a dynamic-prediction
// instance and a static, 2-bit-counter instance share the same stimulus.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, valid, exc, pred;
    logic [31:0] pc, a, b, fetch_pc;
    logic [5:0]  op, func;
    logic [4:0]  rt;

    logic        pred1, v1, t1, m1, tr1, e1;
    logic [15:0] cnt1;
    logic        pred2, v2, t2, m2, tr2, e2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_stall(stall), .in_valid(valid),
        .in_pc(pc), .in_a(a), .in_b(b), .in_op(op), .in_func(func), .in_rt(rt),
        .in_exception(exc), .in_pred_taken(pred), .in_fetch_pc(fetch_pc),
        .out_pred_taken(pred1), .out_valid(v1), .out_taken(t1),
        .out_mispredict(m1), .out_trap(tr1), .out_exception(e1),
        .out_mispred_count(cnt1)
    );

    branch_resolve_unit #(.CNT_W(2), .PRED_EN(1'b0)) dut2 (
        .in_clk(clk), .in_rst_n(rst_n), .in_stall(stall), .in_valid(valid),
        .in_pc(pc), .in_a(a), .in_b(b), .in_op(op), .in_func(func), .in_rt(rt),
        .in_exception(exc), .in_pred_taken(pred), .in_fetch_pc(fetch_pc),
        .out_pred_taken(pred2), .out_valid(v2), .out_taken(t2),
        .out_mispredict(m2), .out_trap(tr2), .out_exception(e2),
        .out_mispred_count(cnt2)
    );

    typedef struct {
        bit v, t, m, tr, e, p;
        int cnt, cnt2;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference state
    int m_bht[64];
    bit r_v, r_t, r_m, r_tr, r_e;
    int r_cnt, r_cnt2;

    function automatic void chk(string nm, longint act, longint expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void model_reset();
        foreach (m_bht[i]) m_bht[i] = 1;
        r_v = 0; r_t = 0; r_m = 0; r_tr = 0; r_e = 0;
        r_cnt = 0; r_cnt2 = 0;
    endfunction

    function automatic void ref_resolve(output bit tk, output bit trp, output bit cd);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        tk = 0; trp = 0; cd = 0;
        if (exc) tk = 1;
        else case (op)
            6'd4: begin cd = 1; tk = (sa == sb); end
            6'd5: begin cd = 1; tk = (sa != sb); end
            6'd6: begin cd = 1; tk = (sa <= 0); end
            6'd7: begin cd = 1; tk = (sa > 0); end
            6'd1: begin
                if (rt == 5'd1)      begin cd = 1; tk = (sa >= 0); end
                else if (rt == 5'd0) begin cd = 1; tk = (sa < 0);  end
            end
            6'd2, 6'd3: tk = 1;
            6'd0: begin
                if (func == 6'd8 || func == 6'd9) tk = 1;
                else if (func == 6'h34) trp = (sa == sb);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_edge();
        bit tk, trp, cd, mis;
        int idx;
        if (stall) return;
        ref_resolve(tk, trp, cd);
        mis = exc || (tk != pred);
        r_v = valid; r_t = valid && tk; r_m = valid && mis;
        r_tr = valid && trp; r_e = valid && exc;
        if (valid && mis) begin
            if (r_cnt < 65535) r_cnt++;
            if (r_cnt2 < 3) r_cnt2++;
        end
        if (valid && cd) begin
            idx = (pc >> 2) % 64;
            if (tk) m_bht[idx] = (m_bht[idx] < 3) ? m_bht[idx] + 1 : 3;
            else    m_bht[idx] = (m_bht[idx] > 0) ? m_bht[idx] - 1 : 0;
        end
    endfunction

    function automatic exp_t snapshot();
        exp_t x;
        x.v = r_v; x.t = r_t; x.m = r_m; x.tr = r_tr; x.e = r_e;
        x.cnt = r_cnt; x.cnt2 = r_cnt2;
        x.p = (m_bht[(fetch_pc >> 2) % 64] >= 2);
        return x;
    endfunction

    task automatic drive(bit v_i, logic [5:0] op_i, logic [5:0] fn_i, logic [4:0] rt_i,
                         logic [31:0] a_i, logic [31:0] b_i, logic [31:0] pc_i,
                         bit p_i, bit e_i, bit s_i, logic [31:0] fpc_i);
        valid = v_i; op = op_i; func = fn_i; rt = rt_i; a = a_i; b = b_i;
        pc = pc_i; pred = p_i; exc = e_i; stall = s_i; fetch_pc = fpc_i;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        q.push_back(snapshot());
        @(negedge clk);
        #1;
    endtask

    task automatic rand_drive();
        logic [5:0] ops [11] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                                 6'h08, 6'h23, 6'h3f};
        logic [5:0] fns [4]  = '{6'd8, 6'd9, 6'h34, 6'h20};
        logic [31:0] av [6]  = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5,
                                 32'h8000_0000, 32'h7FFF_FFFF};
        logic [31:0] aa, bb;
        aa = ($urandom_range(0, 3) == 0) ? $urandom : av[$urandom_range(0, 5)];
        bb = ($urandom_range(0, 1) == 0) ? aa : av[$urandom_range(0, 5)];
        drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 10)],
              fns[$urandom_range(0, 3)], 5'($urandom_range(0, 3)), aa, bb,
              32'($urandom_range(0, 7)) << 2, 1'($urandom), $urandom_range(0, 19) == 0,
              $urandom_range(0, 9) == 0, 32'($urandom_range(0, 7)) << 2);
    endtask

    // Monitor: one expected response per clock, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("valid",     v1,   e.v);   chk("taken",     t1,   e.t);
                chk("mispred",   m1,   e.m);   chk("trap",      tr1,  e.tr);
                chk("exception", e1,   e.e);   chk("count",     cnt1, e.cnt);
                chk("pred",      pred1, e.p);
                chk("s_taken",   t2,   e.t);   chk("s_mispred", m2,   e.m);
                chk("s_count",   cnt2, e.cnt2); chk("s_pred",   pred2, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", v1, 0); chk("rst_taken", t1, 0); chk("rst_mispred", m1, 0);
        chk("rst_count", cnt1, 0); chk("rst_pred", pred1, 0);
        #1 rst_n = 1'b1;

        // BEQ equal, predicted not-taken at pc 0x40
        drive(1, 6'd4, 0, 0, 5, 5, 32'h40, 0, 0, 0, 32'h40); tick();
        chk("beq_taken", t1, 1); chk("beq_mispred", m1, 1);
        chk("beq_count", cnt1, 1); chk("beq_pred", pred1, 1);

        // Signed boundary cases
        drive(1, 6'd1, 0, 5'd1, 32'hFFFF_FFFF, 0, 32'h44, 0, 0, 0, 32'h44); tick();
        chk("bgez_neg", t1, 0);
        drive(1, 6'd1, 0, 5'd0, 32'hFFFF_FFFF, 0, 32'h48, 0, 0, 0, 32'h48); tick();
        chk("bltz_neg", t1, 1);
        drive(1, 6'd7, 0, 0, 0, 0, 32'h4C, 0, 0, 0, 32'h4C); tick();
        chk("bgtz_zero", t1, 0);
        drive(1, 6'd6, 0, 0, 0, 0, 32'h50, 0, 0, 0, 32'h50); tick();
        chk("blez_zero", t1, 1);

        // Saturation at both ends on one entry
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'd5, 0, 0, 1, 2, 32'h80, 1, 0, 0, 32'h80); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive(1, 6'd5, 0, 0, 3, 3, 32'h80, 0, 0, 0, 32'h80); tick();
        end
        chk("bne_sat_pred", pred1, 0);

        // TEQ trap, JR correctly predicted
        drive(1, 6'd0, 6'h34, 0, 7, 7, 32'h60, 0, 0, 0, 32'h60); tick();
        chk("teq_trap", tr1, 1); chk("teq_mispred", m1, 0);
        drive(1, 6'd0, 6'h08, 0, 7, 7, 32'h64, 1, 0, 0, 32'h64); tick();
        chk("jr_taken", t1, 1); chk("jr_mispred", m1, 0);

        // Exception overrides a not-taken BEQ; table entry stays put
        drive(1, 6'd4, 0, 0, 1, 2, 32'h70, 0, 1, 0, 32'h70); tick();
        chk("exc_flag", e1, 1); chk("exc_taken", t1, 1);

        // Stall during a valid branch holds everything
        drive(1, 6'd4, 0, 0, 9, 9, 32'h40, 0, 0, 1, 32'h40); tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40); tick();

        // Mispredict burst drives the 2-bit counter into saturation
        for (int i = 0; i < 5; i++) begin
            drive(1, 6'd2, 0, 0, 0, 0, 32'h90, 0, 0, 0, 32'h90); tick();
        end
        chk("cnt2_sat", cnt2, 3);

        for (int i = 0; i < 600; i++) begin
            rand_drive(); tick();
        end

        // Asynchronous reset between edges
        drive(1, 6'd2, 0, 0, 0, 0, 32'h40, 0, 0, 0, 32'h40); tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", v1, 0); chk("arst_taken", t1, 0); chk("arst_mispred", m1, 0);
        chk("arst_count", cnt1, 0); chk("arst_pred", pred1, 0); chk("arst_s_valid", v2, 0);
        model_reset();
        #1 rst_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            rand_drive(); tick();
        end

        repeat (2) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
